// File: rtl/microcode_dualbank.sv
// Dual-bank microcode store. The sequencer executes from the active bank while a new
// program streams into the shadow bank; a completed load promotes the shadow bank atomically.
module microcode_dualbank #(
  parameter int NUM_ADDRESS_LINES = 5,
  parameter int NUM_WORDS         = 32,
  parameter int NUM_STATE_BITS    = 4,
  parameter int NUM_CONTROL_BITS  = 32,
  parameter int STATE_CAPTURE_BIT = NUM_ADDRESS_LINES,
  parameter int READ_LATENCY      = 0,
  parameter int WORD_W            = NUM_CONTROL_BITS + 2*NUM_STATE_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ADDRESS_LINES-1:0] address,
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [WORD_W-1:0]            load_data,
  output logic                         load_ready,
  input  logic                         swap_req,
  output logic                         loaded,
  output logic [WORD_W-1:0]            load_csum,
  output logic                         active_bank,
  output logic                         ready,
  output logic [NUM_CONTROL_BITS-1:0]  ctl_out,
  output logic [NUM_ADDRESS_LINES-1:0] jadr,
  output logic [NUM_STATE_BITS-1:0]    states
);

  localparam int AW = NUM_ADDRESS_LINES;
  localparam int SB = NUM_STATE_BITS;
  localparam logic [AW:0]   WORDS_EXT = (AW+1)'(NUM_WORDS);
  localparam logic [AW-1:0] LAST_PTR  = AW'(NUM_WORDS-1);

  typedef enum logic [1:0] {IDLE, LOADING, LOADED} load_state_t;

  load_state_t       load_state;
  logic [AW-1:0]     ptr;
  logic [WORD_W-1:0] bank [2][NUM_WORDS];
  logic              accept;
  logic              swap;
  logic [WORD_W-1:0] word_p0;
  logic [WORD_W-1:0] word;
  logic [SB-1:0]     state_value;
  logic [SB-1:0]     state_mask;

  // load_start wins over everything else in the same cycle: its word is dropped
  // and a pending swap is abandoned along with the old load.
  assign accept = ~rst & ~load_start & load_valid & load_ready & (load_state == LOADING);
  assign swap   = ~load_start & (load_state == LOADED) & (~ready | swap_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      load_state <= IDLE;
      ptr        <= '0;
      load_ready <= 1'b0;
      loaded     <= 1'b0;
      load_csum  <= '0;
    end else if (load_start) begin
      load_state <= LOADING;
      ptr        <= '0;
      load_ready <= 1'b1;
      loaded     <= 1'b0;
      load_csum  <= '0;
    end else begin
      case (load_state)
        LOADING: begin
          if (accept) begin
            load_csum <= load_csum ^ load_data;
            ptr       <= ptr + 1'b1;
            if (ptr == LAST_PTR) begin
              load_state <= LOADED;
              load_ready <= 1'b0;
              loaded     <= 1'b1;
            end
          end
        end
        LOADED: begin
          if (swap) begin
            load_state <= IDLE;
            loaded     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) bank[~active_bank][ptr] <= load_data;
  end

  // stage p0: combinational fetch from the active bank
  always_comb begin
    word_p0 = '0;
    if ({1'b0, address} < WORDS_EXT) word_p0 = bank[active_bank][address];
  end

  // stage p1: optional output register, sampled with the pre-swap active bank
  generate
    if (READ_LATENCY == 1) begin : g_reg
      logic [WORD_W-1:0] word_p1;
      always_ff @(posedge clk) begin
        if (rst) word_p1 <= '0;
        else     word_p1 <= word_p0;
      end
      assign word = word_p1;
    end else begin : g_comb
      assign word = word_p0;
    end
  endgenerate

  assign ctl_out     = word[WORD_W-1:2*SB];
  assign jadr        = ctl_out[AW-1:0];
  assign state_value = word[SB-1:0];
  assign state_mask  = word[2*SB-1:SB];

  always_ff @(posedge clk) begin
    if (rst) begin
      active_bank <= 1'b0;
      ready       <= 1'b0;
      states      <= '0;
    end else if (swap) begin
      active_bank <= ~active_bank;
      ready       <= 1'b1;
      states      <= '0;
    end else if (ready && ctl_out[STATE_CAPTURE_BIT]) begin
      states <= (states & ~state_mask) | (state_value & state_mask);
    end
  end

endmodule

// File: tb/tb_microcode_dualbank.sv
// Bench for microcode_dualbank: a combinational-read and a registered-read instance share
// stimulus and are checked every cycle against a bank/queue-level model plus literal expectations.
`timescale 1ns/1ps
module tb_microcode_dualbank;

  localparam int AW  = 5;
  localparam int NW  = 32;
  localparam int SB  = 4;
  localparam int CW  = 32;
  localparam int WW  = CW + 2*SB;
  localparam int CAP = AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic          load_start;
  logic          load_valid;
  logic [WW-1:0] load_data;
  logic          swap_req;

  logic [1:0]    lr, ld, ab, rdy;
  logic [WW-1:0] cs  [2];
  logic [CW-1:0] ctl [2];
  logic [AW-1:0] jd  [2];
  logic [SB-1:0] st  [2];

  always #5 clk = ~clk;

  microcode_dualbank #(.READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .address(address), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(lr[0]),
    .swap_req(swap_req), .loaded(ld[0]), .load_csum(cs[0]), .active_bank(ab[0]),
    .ready(rdy[0]), .ctl_out(ctl[0]), .jadr(jd[0]), .states(st[0]));

  microcode_dualbank #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .address(address), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(lr[1]),
    .swap_req(swap_req), .loaded(ld[1]), .load_csum(cs[1]), .active_bank(ab[1]),
    .ready(rdy[1]), .ctl_out(ctl[1]), .jadr(jd[1]), .states(st[1]));

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  int lr_cnt   = 0;
  int ld_cnt   = 0;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat%0d) at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] word_of(input int gen, input int i);
    logic [WW-1:0] iv;
    iv = WW'(i);
    case (gen)
      0: return iv * 40'h101 + 40'd1;
      1: begin
        if (i == 3) return 40'h205F;
        if (i == 4) return 40'h005F;
        return 40'h0A_0000_0000 | (iv << 16) | (iv + 40'd7);
      end
      2: return ((i == 0) ? 40'h3C_0000_0000 : 40'h0) | (iv << 16) | (iv + 40'd1);
      default: return 40'hFF_FFFF_0000 ^ iv;
    endcase
  endfunction

  // Reference model: bank contents, load progress, executing bank and state bits.
  logic [WW-1:0] mb [2][NW];
  bit            known [2];
  int            phase;        // 0 idle, 1 accepting words, 2 complete awaiting swap
  int            mptr;
  logic [WW-1:0] mcsum;
  bit            mact, mrdy;
  logic [SB-1:0] mst [2];
  bit            sknown [2];
  logic [WW-1:0] mw1;
  bit            mw1_known;
  logic [WW-1:0] ew;

  task automatic capture(input int k, input logic [WW-1:0] w, input bit wk);
    if (!wk) sknown[k] = 1'b0;
    else if (w[CAP + 2*SB]) begin
      for (int i = 0; i < SB; i++)
        if (w[SB + i]) mst[k][i] = w[i];
    end
  endtask

  always @(posedge clk) begin
    logic [WW-1:0] p0, p1;
    bit p0k, p1k, do_swap;
    p0  = mb[mact][address];
    p0k = known[mact];
    p1  = mw1;
    p1k = mw1_known;
    mw1 = p0;
    mw1_known = p0k;
    if (rst) begin
      phase = 0; mptr = 0; mcsum = '0; mact = 1'b0; mrdy = 1'b0;
      mst[0] = '0; mst[1] = '0; sknown[0] = 1'b1; sknown[1] = 1'b1;
      mw1 = '0; mw1_known = 1'b1;
    end else begin
      do_swap = 1'b0;
      if (load_start) begin
        phase = 1; mptr = 0; mcsum = '0;
      end else if (phase == 1 && load_valid) begin
        mb[!mact][mptr] = load_data;
        mcsum = mcsum ^ load_data;
        if (mptr == NW-1) phase = 2;
        mptr++;
      end else if (phase == 2 && (!mrdy || swap_req)) begin
        do_swap = 1'b1;
      end
      if (do_swap) begin
        mst[0] = '0; mst[1] = '0; sknown[0] = 1'b1; sknown[1] = 1'b1;
        mact = !mact; mrdy = 1'b1; phase = 0; known[mact] = 1'b1;
      end else if (mrdy) begin
        capture(0, p0, p0k);
        capture(1, p1, p1k);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (lr[0]) lr_cnt++;
      if (ld[0]) ld_cnt++;
      for (int k = 0; k < 2; k++) begin
        chk("load_ready",  k, 64'(lr[k]),  64'(phase == 1));
        chk("loaded",      k, 64'(ld[k]),  64'(phase == 2));
        chk("load_csum",   k, 64'(cs[k]),  64'(mcsum));
        chk("active_bank", k, 64'(ab[k]),  64'(mact));
        chk("ready",       k, 64'(rdy[k]), 64'(mrdy));
        if (sknown[k]) chk("states", k, 64'(st[k]), 64'(mst[k]));
        if ((k == 0) ? known[mact] : mw1_known) begin
          ew = (k == 0) ? mb[mact][address] : mw1;
          chk("ctl_out", k, 64'(ctl[k]), 64'(ew[WW-1:2*SB]));
          chk("jadr",    k, 64'(jd[k]),  64'(ew[2*SB+AW-1:2*SB]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    load_valid = 1'b0;
    step();
    load_start = 1'b0;
  endtask

  task automatic stream(input int gen, input int count, input bit pause);
    int sent, budget;
    bit v, acc;
    sent = 0;
    budget = 0;
    while (sent < count && budget < 400) begin
      v = pause ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_valid = v;
      load_data  = word_of(gen, sent);
      @(negedge clk);
      acc = v && lr[0];
      step();
      if (acc) sent++;
      budget++;
    end
    load_valid = 1'b0;
    chk("stream_words_accepted", 0, 64'(sent), 64'(count));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; address = 5'd5; load_start = 1'b0; load_valid = 1'b0;
    load_data = '0; swap_req = 1'b0;
    step();
    cmp_en = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_load_ready", k, 64'(lr[k]), 64'd0);
      chk("rst_loaded",     k, 64'(ld[k]), 64'd0);
      chk("rst_active",     k, 64'(ab[k]), 64'd0);
      chk("rst_ready",      k, 64'(rdy[k]), 64'd0);
      chk("rst_states",     k, 64'(st[k]), 64'd0);
      chk("rst_csum",       k, 64'(cs[k]), 64'd0);
    end
    rst = 1'b0;
    step();

    // first program, valid held high, auto-swap into bank 1
    pulse_start();
    stream(0, 32, 1'b0);
    repeat (4) step();
    chk("load_ready_cycles", 0, 64'(lr_cnt), 64'd32);
    chk("loaded_pulse_cycles", 0, 64'(ld_cnt), 64'd1);
    chk("auto_swap_active", 0, 64'(ab[0]), 64'd1);
    chk("auto_swap_ready", 0, 64'(rdy[0]), 64'd1);
    chk("ctl_addr5_prog0", 0, 64'(ctl[0]), 64'h0000_0005);
    chk("csum_prog0", 0, 64'(cs[0]), 64'h00_0000_0020);

    // second program into bank 0 with gaps; bank 1 keeps executing
    pulse_start();
    stream(1, 32, 1'b1);
    chk("ctl_unchanged_during_load", 0, 64'(ctl[0]), 64'h0000_0005);
    repeat (5) step();
    chk("loaded_held", 0, 64'(ld[0]), 64'd1);
    chk("active_before_swap", 0, 64'(ab[0]), 64'd1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("swap_active", 0, 64'(ab[0]), 64'd0);
    chk("swap_states", 0, 64'(st[0]), 64'd0);
    chk("swap_ctl_new_bank", 0, 64'(ctl[0]), 64'h0A00_0500);
    chk("swap_ctl_reg_old_bank", 1, 64'(ctl[1]), 64'h0000_0005);
    step();
    chk("ctl_reg_new_bank", 1, 64'(ctl[1]), 64'h0A00_0500);

    // state capture: word 3 captures (mask 0101, value 1111), word 4 has capture clear
    address = 5'd3;
    step();
    chk("capture_lat0", 0, 64'(st[0]), 64'h5);
    chk("capture_lat1_not_yet", 1, 64'(st[1]), 64'h0);
    address = 5'd4;
    step();
    chk("no_capture_lat0", 0, 64'(st[0]), 64'h5);
    chk("capture_lat1", 1, 64'(st[1]), 64'h5);
    address = 5'd5;
    step();
    chk("no_capture_lat1", 1, 64'(st[1]), 64'h5);

    // restarted load: 10 junk words then 32 real ones into bank 1
    pulse_start();
    stream(3, 10, 1'b0);
    pulse_start();
    stream(2, 32, 1'b0);
    repeat (2) step();
    chk("restart_loaded", 0, 64'(ld[0]), 64'd1);
    chk("restart_csum", 0, 64'(cs[0]), 64'h3C_0000_0020);
    chk("restart_no_autoswap", 0, 64'(ab[0]), 64'd0);

    // swap coinciding with a capture word on both instances
    address = 5'd3;
    step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("swap_over_capture_lat0", 0, 64'(st[0]), 64'h0);
    chk("swap_over_capture_lat1", 1, 64'(st[1]), 64'h0);
    chk("swap_over_capture_active", 0, 64'(ab[0]), 64'd1);
    step();
    chk("reg_read_addr3", 1, 64'(ctl[1]), 64'h0000_0300);
    address = 5'd7;
    #1;
    chk("comb_read_addr7", 0, 64'(ctl[0]), 64'h0000_0700);
    chk("reg_read_still_addr3", 1, 64'(ctl[1]), 64'h0000_0300);
    step();
    chk("reg_read_addr7", 1, 64'(ctl[1]), 64'h0000_0700);

    // reset in the middle of a load
    pulse_start();
    stream(1, 5, 1'b0);
    load_valid = 1'b1;
    load_data = 40'hDE_AD00_BEEF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    load_valid = 1'b0;
    chk("midrst_load_ready", 0, 64'(lr[0]), 64'd0);
    chk("midrst_loaded", 0, 64'(ld[0]), 64'd0);
    chk("midrst_ready", 0, 64'(rdy[0]), 64'd0);
    chk("midrst_active", 0, 64'(ab[0]), 64'd0);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    chk("post_rst_swap_ignored_active", 0, 64'(ab[0]), 64'd0);
    chk("post_rst_swap_ignored_ready", 1, 64'(rdy[1]), 64'd0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/microcode_dualbank.md
Name: microcode_dualbank

Overview:
- Parametrised successor to the single-bank microcode store for the sequencer.
- Holds two banks of microcode words. The sequencer executes from the active bank while a new program streams into the shadow bank over a valid/ready handshake.
- A completed load swaps banks atomically, so programs can be replaced without halting.
- Adds optional registered read, load checksum, and a state-bit register updated under microcode control.

Parameters:
- NUM_ADDRESS_LINES, 5, width of the execution address and of the jadr field.
- NUM_WORDS, 32, words per bank; must satisfy NUM_WORDS <= 2**NUM_ADDRESS_LINES.
- NUM_STATE_BITS, 4, width of the state-value field and of the transition-mask field.
- NUM_CONTROL_BITS, 32, control field width; must be >= NUM_ADDRESS_LINES+1.
- STATE_CAPTURE_BIT, NUM_ADDRESS_LINES, index within the control field of the state-capture enable.
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read.
- WORD_W, NUM_CONTROL_BITS+2*NUM_STATE_BITS, derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- address  in  NUM_ADDRESS_LINES  execution read address into the active bank
- load_start  in  1  pulse: begin a new load into the shadow bank
- load_valid  in  1  load_data is valid
- load_data  in  WORD_W  microcode word being loaded
- load_ready  out  1  block accepts load_data this cycle
- swap_req  in  1  request promotion of the loaded shadow bank
- loaded  out  1  shadow bank is fully loaded and awaiting swap
- load_csum  out  WORD_W  XOR of all words accepted in the current or last load
- active_bank  out  1  index of the executing bank
- ready  out  1  a valid program is executing
- ctl_out  out  NUM_CONTROL_BITS  control field of the current word
- jadr  out  NUM_ADDRESS_LINES  ctl_out[NUM_ADDRESS_LINES-1:0]
- states  out  NUM_STATE_BITS  state-bit register

Behaviour:
- Word layout: state_value = [NUM_STATE_BITS-1:0]; transition mask = [2*NUM_STATE_BITS-1:NUM_STATE_BITS]; ctl_out = [WORD_W-1:2*NUM_STATE_BITS].
- Reset values:
  - load FSM = IDLE; write pointer = 0; load_ready = 0; loaded = 0; load_csum = 0.
  - active_bank = 0; ready = 0; states = 0.
  - Read register (READ_LATENCY=1) = 0.
  - Bank contents are not cleared.
- Load FSM states:
  - IDLE: load_ready = 0. On load_start: pointer := 0, csum := 0, go to LOADING.
  - LOADING: load_ready = 1.
    - On load_valid & load_ready: write shadow[pointer], csum ^= load_data, pointer += 1.
    - When the word at pointer = NUM_WORDS-1 is accepted, go to LOADED; load_ready drops the following cycle.
  - LOADED: loaded = 1, load_ready = 0.
    - If ready = 0 (first load after reset): auto-swap on the next cycle, no swap_req needed.
    - Otherwise swap on the cycle swap_req is sampled high.
    - Swap: active_bank toggles, states := 0, ready := 1, go to IDLE.
- Only the shadow bank (~active_bank) is ever written. The active bank is never modified while executing.
- load_start is accepted in any FSM state and restarts the load (pointer 0, csum 0, loaded cleared). The word presented in the same cycle as load_start is not written.
- swap_req outside LOADED is ignored. load_valid outside LOADING is ignored and no write occurs.
- Read path:
  - READ_LATENCY=0: word = bank[active_bank][address], combinational.
  - READ_LATENCY=1: word registered at each clk edge from the current active_bank and address.
  - On a swap edge, the registered word is read from the old bank. The new bank is visible to the next sampled address.
  - address >= NUM_WORDS: word = 0.
- State update: each clk, for each bit i, if ctl_out[STATE_CAPTURE_BIT] & mask[i], then states[i] := state_value[i]. Uses the word as presented on ctl_out. Disabled while ready = 0. A swap takes priority over a capture in the same cycle.
- load_csum holds its value after the load completes, until the next load_start.

Test Plan:
- Reset, stream 32 words (w[i] = i*0x0101+1) with valid held high → load_ready high 32 cycles; loaded pulses; auto-swap: active_bank = 1, ready = 1; ctl_out at address 5 = w[5][39:8]; load_csum = XOR of all w.
- While executing bank 1, load bank 0 with a different program, pause valid randomly → bank 1 outputs unchanged throughout; loaded = 1 held until swap_req; one cycle after swap_req active_bank = 0, states = 0, new contents read.
- Word with capture bit set, mask = 4'b0101, value = 4'b1111, from states = 0 → next cycle states = 4'b0101. Same word with capture bit clear → states unchanged.
- load_start issued after 10 accepted words → pointer restarts; only 32 further words complete the load; load_csum covers only those 32 words.
- READ_LATENCY=1: address changes 3 → 7 → ctl_out shows word 7 exactly one cycle later. Swap plus capture in the same cycle → states = 0.
- rst asserted mid-load → load_ready = 0, loaded = 0, ready = 0, active_bank = 0 the next cycle; swap_req afterwards has no effect.
